// File: rtl/uart_fifo.sv
// uart_fifo: bus-mapped UART with TX/RX FIFOs, baud divisor,
// optional parity, sticky error flags and level interrupts.
module uart_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int RESET_DIV = 433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  busAddr,
  inout  wire  [15:0] busData,
  input  logic        busEn,
  input  logic        busWr,
  output logic        sigTxInt,
  output logic        sigRxInt,
  output logic        txOut,
  input  logic        rxIn
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [3:0] LAST = 4'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_t;

  logic        en_q;
  logic [15:0] rdata_q, rdata_d;
  logic [5:0]  ctrl_q;
  logic [15:0] div_q, eff_div, rhalf;
  logic        ovr_q, perr_q, ferr_q, txdrop_q;
  logic        acc, wr_data, wr_ctrl, wr_div, wr_stat;
  logic        rd_data, flush;

  assign acc     = busEn & ~en_q;
  assign wr_data = acc & busWr & (busAddr == 2'd0);
  assign wr_ctrl = acc & busWr & (busAddr == 2'd1);
  assign wr_div  = acc & busWr & (busAddr == 2'd2);
  assign wr_stat = acc & busWr & (busAddr == 2'd3);
  assign rd_data = acc & ~busWr & (busAddr == 2'd0);
  assign flush   = wr_ctrl & busData[6];
  assign busData = (busEn && !busWr) ? rdata_q : 'z;

  assign eff_div = (div_q < 16'd3) ? 16'd3 : div_q;
  // (eff+1)/2 - 1: start-bit half period, minus the entry cycle
  assign rhalf = (eff_div >> 1) - {15'd0, ~eff_div[0]};

  // TX FIFO
  logic [DATA_W-1:0] txm_q [DEPTH];
  logic [AW-1:0]     txw_q, txr_q;
  logic [CW-1:0]     txc_q;
  logic              tx_full, tx_empty, tx_pop, tx_push;
  logic              tx_drop_set;

  assign tx_full     = txc_q == FULL;
  assign tx_empty    = txc_q == '0;
  assign tx_push     = wr_data & (~tx_full | tx_pop);
  assign tx_drop_set = wr_data & tx_full & ~tx_pop;

  always_ff @(posedge clk)
    if (tx_push) txm_q[txw_q] <= busData[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      txw_q <= '0;
      txr_q <= '0;
      txc_q <= '0;
    end else begin
      if (tx_push) txw_q <= txw_q + AW'(1);
      if (tx_pop)  txr_q <= txr_q + AW'(1);
      txc_q <= txc_q + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // RX FIFO
  logic [DATA_W-1:0] rxm_q [DEPTH];
  logic [AW-1:0]     rxw_q, rxr_q;
  logic [CW-1:0]     rxc_q;
  logic              rx_full, rx_empty, rx_pop, rx_push;
  logic              rx_acc, ovr_set;
  logic [DATA_W-1:0] rsh_q, rsh_d;

  assign rx_full  = rxc_q == FULL;
  assign rx_empty = rxc_q == '0;
  assign rx_pop   = rd_data & ~rx_empty;
  assign rx_acc   = rx_push & (~rx_full | rx_pop);
  assign ovr_set  = rx_push & rx_full & ~rx_pop;

  always_ff @(posedge clk)
    if (rx_acc) rxm_q[rxw_q] <= rsh_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rxw_q <= '0;
      rxr_q <= '0;
      rxc_q <= '0;
    end else begin
      if (rx_acc) rxw_q <= rxw_q + AW'(1);
      if (rx_pop) rxr_q <= rxr_q + AW'(1);
      rxc_q <= rxc_q + CW'(rx_acc) - CW'(rx_pop);
    end
  end

  // TX engine
  st_t               txs_q, txs_d;
  logic [15:0]       tcnt_q, tcnt_d;
  logic [3:0]        tidx_q, tidx_d;
  logic [DATA_W-1:0] tsh_q, tsh_d, tdat_q, tdat_d;
  logic              txo_q, txo_d, tbit, tx_busy;

  assign tbit    = tcnt_q == 16'd0;
  assign tx_busy = txs_q != S_IDLE;

  always_comb begin
    txs_d  = txs_q;
    tcnt_d = tcnt_q;
    tidx_d = tidx_q;
    tsh_d  = tsh_q;
    tdat_d = tdat_q;
    tx_pop = 1'b0;
    if (txs_q != S_IDLE)
      tcnt_d = tbit ? eff_div : tcnt_q - 16'd1;
    unique case (txs_q)
      S_IDLE: if (ctrl_q[0] && !tx_empty) begin
        tx_pop = 1'b1;
        tsh_d  = txm_q[txr_q];
        tdat_d = txm_q[txr_q];
        tcnt_d = eff_div;
        txs_d  = S_START;
      end
      S_START: if (tbit) begin
        tidx_d = 4'd0;
        txs_d  = S_DATA;
      end
      S_DATA: if (tbit) begin
        tsh_d = tsh_q >> 1;
        if (tidx_q == LAST)
          txs_d = ctrl_q[2] ? S_PAR : S_STOP;
        else
          tidx_d = tidx_q + 4'd1;
      end
      S_PAR: if (tbit) txs_d = S_STOP;
      S_STOP: if (tbit) begin
        if (ctrl_q[0] && !tx_empty) begin
          tx_pop = 1'b1;
          tsh_d  = txm_q[txr_q];
          tdat_d = txm_q[txr_q];
          txs_d  = S_START;
        end else begin
          txs_d = S_IDLE;
        end
      end
      default: txs_d = S_IDLE;
    endcase
    txo_d = 1'b1;
    unique case (txs_d)
      S_START: txo_d = 1'b0;
      S_DATA:  txo_d = tsh_d[0];
      S_PAR:   txo_d = ^tdat_d ^ ctrl_q[3];
      default: txo_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txs_q  <= S_IDLE;
      tcnt_q <= '0;
      tidx_q <= '0;
      tsh_q  <= '0;
      tdat_q <= '0;
      txo_q  <= 1'b1;
    end else begin
      txs_q  <= txs_d;
      tcnt_q <= tcnt_d;
      tidx_q <= tidx_d;
      tsh_q  <= tsh_d;
      tdat_q <= tdat_d;
      txo_q  <= txo_d;
    end
  end

  assign txOut = txo_q;

  // RX engine
  logic        rs1_q, rs2_q;
  st_t         rxs_q, rxs_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic [3:0]  ridx_q, ridx_d;
  logic        rpar_q, rpar_d, rbit;
  logic        perr_set, ferr_set;

  assign rbit = rcnt_q == 16'd0;

  always_comb begin
    rxs_d    = rxs_q;
    rcnt_d   = rcnt_q;
    ridx_d   = ridx_q;
    rsh_d    = rsh_q;
    rpar_d   = rpar_q;
    rx_push  = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    if (rxs_q != S_IDLE)
      rcnt_d = rbit ? eff_div : rcnt_q - 16'd1;
    unique case (rxs_q)
      S_IDLE: if (!rs2_q) begin
        rcnt_d = rhalf;
        rxs_d  = S_START;
      end
      S_START: if (rbit) begin
        ridx_d = 4'd0;
        rxs_d  = rs2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rbit) begin
        rsh_d = {rs2_q, rsh_q[DATA_W-1:1]};
        if (ridx_q == LAST)
          rxs_d = ctrl_q[2] ? S_PAR : S_STOP;
        else
          ridx_d = ridx_q + 4'd1;
      end
      S_PAR: if (rbit) begin
        rpar_d = rs2_q;
        rxs_d  = S_STOP;
      end
      S_STOP: if (rbit) begin
        rxs_d = S_IDLE;
        if (!rs2_q) begin
          ferr_set = 1'b1;
        end else begin
          rx_push  = 1'b1;
          perr_set = ctrl_q[2] & (rpar_q != (^rsh_q ^ ctrl_q[3]));
        end
      end
      default: rxs_d = S_IDLE;
    endcase
    if (!ctrl_q[1]) begin
      rxs_d    = S_IDLE;
      rx_push  = 1'b0;
      perr_set = 1'b0;
      ferr_set = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_q  <= 1'b1;
      rs2_q  <= 1'b1;
      rxs_q  <= S_IDLE;
      rcnt_q <= '0;
      ridx_q <= '0;
      rsh_q  <= '0;
      rpar_q <= 1'b0;
    end else begin
      rs1_q  <= rxIn;
      rs2_q  <= rs1_q;
      rxs_q  <= rxs_d;
      rcnt_q <= rcnt_d;
      ridx_q <= ridx_d;
      rsh_q  <= rsh_d;
      rpar_q <= rpar_d;
    end
  end

  // registers and read path
  logic [15:0] status;
  logic [6:0]  rx_cnt7;

  assign rx_cnt7 = 7'(rxc_q);
  assign status  = {rx_cnt7, txdrop_q, tx_busy, ferr_q, perr_q,
                    ovr_q, rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    rdata_d = rdata_q;
    if (acc && !busWr) begin
      unique case (busAddr)
        2'd0:    rdata_d = rx_empty ? 16'h0 : 16'(rxm_q[rxr_q]);
        2'd1:    rdata_d = {10'h0, ctrl_q};
        2'd2:    rdata_d = div_q;
        default: rdata_d = status;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      rdata_q  <= '0;
      ctrl_q   <= 6'h03;
      div_q    <= 16'(RESET_DIV);
      ovr_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      txdrop_q <= 1'b0;
    end else begin
      en_q    <= busEn;
      rdata_q <= rdata_d;
      if (wr_ctrl) ctrl_q <= busData[5:0];
      if (wr_div)  div_q  <= busData;
      ovr_q    <= ovr_set | (ovr_q & ~(wr_stat & busData[4]));
      perr_q   <= perr_set | (perr_q & ~(wr_stat & busData[5]));
      ferr_q   <= ferr_set | (ferr_q & ~(wr_stat & busData[6]));
      txdrop_q <= tx_drop_set | (txdrop_q & ~(wr_stat & busData[8]));
    end
  end

  assign sigTxInt = ctrl_q[4] & tx_empty & ~tx_busy;
  assign sigRxInt = ctrl_q[5] & (~rx_empty | ovr_q);

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: randomized self-checking bench for uart_fifo
// against a frame-level reference model.
module tb_uart_fifo;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, busEn, busWr, rx_drv, loop, tb_drv;
  logic [1:0]  busAddr;
  logic [15:0] tb_bd;
  wire  [15:0] busData;
  wire         sigTxInt, sigRxInt, txOut, rxIn;
  int          checks = 0;
  int          errors = 0;

  assign busData = tb_drv ? tb_bd : 'z;
  assign rxIn    = loop ? txOut : rx_drv;

  always #5 clk = ~clk;

  uart_fifo #(.DATA_W(8), .DEPTH(DEPTH), .RESET_DIV(433)) dut (
    .clk(clk), .rst(rst), .busAddr(busAddr), .busData(busData),
    .busEn(busEn), .busWr(busWr), .sigTxInt(sigTxInt),
    .sigRxInt(sigRxInt), .txOut(txOut), .rxIn(rxIn)
  );

  // line-level frame: bit 0 start, data LSB first, parity, stop
  function automatic int frame_bits(input logic [7:0] d, input bit pen,
                                    input bit odd, output logic [15:0] b);
    if (pen) begin
      b = {5'b0, 1'b1, (odd ? ~^d : ^d), d, 1'b0};
      return 11;
    end
    b = {6'b0, 1'b1, d, 1'b0};
    return 10;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    busAddr = a; busWr = 1'b1; tb_bd = d; tb_drv = 1'b1; busEn = 1'b1;
    @(negedge clk);
    busEn = 1'b0; tb_drv = 1'b0; busWr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    busAddr = a; busWr = 1'b0; busEn = 1'b1;
    @(negedge clk);
    d = busData;
    busEn = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tx_capture(input int per, input int nb, input bit imm,
                            output logic [15:0] bits, output bit stable,
                            output bit found);
    found = 1'b0; stable = 1'b1; bits = '0;
    for (int i = 0; i < (imm ? 1 : 300) && !found; i++) begin
      @(negedge clk);
      if (txOut === 1'b0) found = 1'b1;
    end
    if (!found) return;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < per; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (c == 0) bits[b] = txOut;
        else if (txOut !== bits[b]) stable = 1'b0;
      end
  endtask

  task automatic send_rx(input logic [7:0] d, input int per, input bit pen,
                         input bit odd, input bit flip, input bit badstop);
    logic [15:0] b;
    int n;
    n = frame_bits(d, pen, odd, b);
    if (flip) b[9] = ~b[9];
    if (badstop) b[n-1] = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_drv = b[i];
      repeat (per) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (per) @(negedge clk);
  endtask

  task automatic wait_rx(output bit ok);
    logic [15:0] s;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      bus_read(2'd3, s);
      if (!s[3]) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [15:0] r;
    do_reset();
    checks++;
    if (txOut !== 1'b1) begin
      errors++; $display("FAIL reset_txOut: got %b want 1", txOut);
    end
    checks++;
    if ({sigTxInt, sigRxInt} !== 2'b00) begin
      errors++; $display("FAIL reset_ints: got %b want 00", {sigTxInt, sigRxInt});
    end
    bus_read(2'd3, r);
    checks++;
    if (r !== 16'h000A) begin
      errors++; $display("FAIL reset_status: got %h want 000a", r);
    end
    bus_read(2'd1, r);
    checks++;
    if (r !== 16'h0003) begin
      errors++; $display("FAIL reset_ctrl: got %h want 0003", r);
    end
    bus_read(2'd2, r);
    checks++;
    if (r !== 16'd433) begin
      errors++; $display("FAIL reset_div: got %0d want 433", r);
    end
  endtask

  task automatic test_tx_waveform();
    logic [15:0] exp, got, r;
    logic [7:0] d;
    bit st, fd, pen, odd;
    int n, div, per;
    do_reset();
    bus_write(2'd2, 16'd3);
    bus_write(2'd0, 16'h0055);
    n = frame_bits(8'h55, 1'b0, 1'b0, exp);
    tx_capture(4, n, 1'b0, got, st, fd);
    checks++;
    if (!fd || !st || got !== exp) begin
      errors++;
      $display("FAIL tx_55: got %h found %b stable %b want %h", got, fd, st, exp);
    end
    repeat (2) @(negedge clk);
    bus_read(2'd3, r);
    checks++;
    if (r !== 16'h000A) begin
      errors++; $display("FAIL tx_55_idle: got %h want 000a", r);
    end
    for (int k = 0; k < 6; k++) begin
      div = $urandom_range(0, 6);
      pen = 1'($urandom_range(0, 1));
      odd = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      per = ((div < 3) ? 3 : div) + 1;
      bus_write(2'd2, 16'(div));
      bus_write(2'd1, {12'h0, odd, pen, 2'b11});
      bus_write(2'd0, {8'h0, d});
      n = frame_bits(d, pen, odd, exp);
      tx_capture(per, n, 1'b0, got, st, fd);
      checks++;
      if (!fd || !st || got !== exp) begin
        errors++;
        $display("FAIL tx_rand div=%0d: got %h found %b stable %b want %h",
                 div, got, fd, st, exp);
      end
      repeat (2) @(negedge clk);
      bus_read(2'd2, r);
      checks++;
      if (r !== 16'(div)) begin
        errors++; $display("FAIL div_rd: got %0d want %0d", r, div);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] r;
    bit fd;
    do_reset();
    bus_write(2'd2, 16'd3);
    bus_write(2'd0, 16'h00F0);
    bus_write(2'd0, 16'h0033);
    fd = 1'b0;
    for (int i = 0; i < 20 && !fd; i++) begin
      @(negedge clk);
      if (txOut === 1'b0) fd = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!fd || txOut !== 1'b1) begin
      errors++; $display("FAIL rst_mid: got %b found %b want 1", txOut, fd);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus_read(2'd3, r);
    checks++;
    if (r !== 16'h000A || txOut !== 1'b1) begin
      errors++; $display("FAIL rst_mid_status: got %h want 000a", r);
    end
  endtask

  task automatic test_loopback_parity();
    logic [15:0] r;
    logic [7:0] d;
    bit ok, pen, odd;
    int div;
    do_reset();
    loop = 1'b1;
    bus_write(2'd2, 16'd7);
    bus_write(2'd1, 16'h0007);
    bus_write(2'd0, 16'h00A5);
    wait_rx(ok);
    bus_read(2'd0, r);
    checks++;
    if (!ok || r !== 16'h00A5) begin
      errors++; $display("FAIL loop_a5: got %h ok %b want 00a5", r, ok);
    end
    bus_read(2'd3, r);
    checks++;
    if (r[5] !== 1'b0) begin
      errors++; $display("FAIL loop_perr: got %b want 0", r[5]);
    end
    for (int k = 0; k < 5; k++) begin
      div = $urandom_range(3, 9);
      pen = 1'($urandom_range(0, 1));
      odd = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      bus_write(2'd2, 16'(div));
      bus_write(2'd1, {12'h0, odd, pen, 2'b11});
      bus_write(2'd0, {8'h0, d});
      wait_rx(ok);
      bus_read(2'd0, r);
      checks++;
      if (!ok || r !== {8'h0, d}) begin
        errors++; $display("FAIL loop_rand: got %h ok %b want %h", r, ok, d);
      end
      bus_read(2'd3, r);
      checks++;
      if (r[6:4] !== 3'b000) begin
        errors++; $display("FAIL loop_rand_flags: got %b want 000", r[6:4]);
      end
    end
    loop = 1'b0;
    bus_write(2'd2, 16'd7);
    bus_write(2'd1, 16'h0007);
    send_rx(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_rx(ok);
    bus_read(2'd3, r);
    checks++;
    if (!ok || r[5] !== 1'b1) begin
      errors++; $display("FAIL flip_perr: got %b ok %b want 1", r[5], ok);
    end
    bus_read(2'd0, r);
    checks++;
    if (r !== 16'h00A5) begin
      errors++; $display("FAIL flip_data: got %h want 00a5", r);
    end
  endtask

  task automatic test_tx_fifo_full();
    logic [15:0] r, exp, got;
    logic [7:0] q[$];
    logic [7:0] d;
    bit st, fd;
    int n;
    do_reset();
    bus_write(2'd2, 16'd3);
    bus_write(2'd1, 16'h0002);
    for (int i = 0; i <= DEPTH; i++) begin
      d = 8'($urandom);
      bus_write(2'd0, {8'h0, d});
      if (q.size() < DEPTH) q.push_back(d);
    end
    bus_read(2'd3, r);
    checks++;
    if (r !== 16'h0109) begin
      errors++; $display("FAIL txfull_status: got %h want 0109", r);
    end
    bus_write(2'd1, 16'h0003);
    for (int k = 0; k < DEPTH; k++) begin
      n = frame_bits(q[k], 1'b0, 1'b0, exp);
      tx_capture(4, n, k != 0, got, st, fd);
      checks++;
      if (!fd || !st || got !== exp) begin
        errors++;
        $display("FAIL b2b_%0d: got %h found %b stable %b want %h",
                 k, got, fd, st, exp);
      end
    end
    repeat (3) @(negedge clk);
    bus_read(2'd3, r);
    checks++;
    if (r !== 16'h010A) begin
      errors++; $display("FAIL b2b_done: got %h want 010a", r);
    end
    bus_write(2'd3, 16'h0100);
    bus_read(2'd3, r);
    checks++;
    if (r !== 16'h000A) begin
      errors++; $display("FAIL txdrop_clr: got %h want 000a", r);
    end
    bus_write(2'd1, 16'h0002);
    bus_write(2'd0, 16'h0011);
    bus_write(2'd0, 16'h0022);
    bus_write(2'd1, 16'h0043);
    bus_read(2'd3, r);
    checks++;
    if (r !== 16'h000A || txOut !== 1'b1) begin
      errors++; $display("FAIL flush_status: got %h want 000a", r);
    end
    bus_read(2'd1, r);
    checks++;
    if (r !== 16'h0003) begin
      errors++; $display("FAIL flush_ctrl: got %h want 0003", r);
    end
  endtask

  task automatic test_rx_overrun();
    logic [15:0] r, exp;
    logic [7:0] q[$];
    logic [7:0] d;
    do_reset();
    loop = 1'b0;
    bus_write(2'd2, 16'd7);
    bus_write(2'd1, 16'h0023);
    for (int i = 0; i <= DEPTH; i++) begin
      d = 8'($urandom);
      send_rx(d, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      if (q.size() < DEPTH) q.push_back(d);
    end
    repeat (10) @(negedge clk);
    exp = 16'h0016 | 16'(DEPTH << 9);
    bus_read(2'd3, r);
    checks++;
    if (r !== exp) begin
      errors++; $display("FAIL ovr_status: got %h want %h", r, exp);
    end
    checks++;
    if (sigRxInt !== 1'b1) begin
      errors++; $display("FAIL rxint_on: got %b want 1", sigRxInt);
    end
    bus_write(2'd1, 16'h0003);
    checks++;
    if (sigRxInt !== 1'b0) begin
      errors++; $display("FAIL rxint_mask: got %b want 0", sigRxInt);
    end
    bus_write(2'd1, 16'h0023);
    bus_write(2'd3, 16'h0010);
    exp = 16'h0006 | 16'(DEPTH << 9);
    bus_read(2'd3, r);
    checks++;
    if (r !== exp) begin
      errors++; $display("FAIL ovr_clr: got %h want %h", r, exp);
    end
    for (int k = 0; k < DEPTH; k++) begin
      bus_read(2'd0, r);
      checks++;
      if (r !== {8'h0, q[k]}) begin
        errors++; $display("FAIL rx_order_%0d: got %h want %h", k, r, q[k]);
      end
    end
    bus_read(2'd0, r);
    checks++;
    if (r !== 16'h0000 || sigRxInt !== 1'b0) begin
      errors++; $display("FAIL rx_empty_rd: got %h int %b want 0000", r, sigRxInt);
    end
  endtask

  task automatic test_rx_errors();
    logic [15:0] r;
    do_reset();
    loop = 1'b0;
    bus_write(2'd2, 16'd15);
    @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    bus_read(2'd3, r);
    checks++;
    if (r !== 16'h000A) begin
      errors++; $display("FAIL glitch: got %h want 000a", r);
    end
    send_rx(8'($urandom), 16, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    bus_read(2'd3, r);
    checks++;
    if (r !== 16'h004A) begin
      errors++; $display("FAIL frame_err: got %h want 004a", r);
    end
    bus_write(2'd3, 16'h0040);
    bus_read(2'd3, r);
    checks++;
    if (r !== 16'h000A) begin
      errors++; $display("FAIL ferr_clr: got %h want 000a", r);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; busEn = 1'b0; busWr = 1'b0; busAddr = 2'd0;
    tb_bd = '0; tb_drv = 1'b0; rx_drv = 1'b1; loop = 1'b0;
    test_reset();
    test_tx_waveform();
    test_reset_midframe();
    test_loopback_parity();
    test_tx_fifo_full();
    test_rx_overrun();
    test_rx_errors();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
